// File: rtl/jpeg_pixel_sink.sv
// jpeg_pixel_sink: receives MCU-ordered pixels from the decoder, maps each one to
// a raster frame-buffer address, converts RGB888 to RGB444 and issues registered
// frame-buffer writes that stall on fb_ready. A frame ends after the last pixel
// of the bottom-right MCU has been written, signalled by a one-cycle frame_done.
// Optional build macro: JPEG_PIXEL_SINK_ROUND_EN selects rounded (saturating)
// colour nibbles instead of plain truncation.
module jpeg_pixel_sink #(
    parameter int FB_W          = 32,
    parameter int FB_H          = 32,
    parameter int FB_ADDR_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     co_en,
    input  logic                     co_411,
    input  logic [12:0]              co_mcu_w,
    input  logic [12:0]              co_mcu_h,
    input  logic                     bo_we,
    input  logic                     bo_begin,
    input  logic                     bo_end,
    input  logic [7:0]               bo_r,
    input  logic [7:0]               bo_g,
    input  logic [7:0]               bo_b,
    input  logic [7:0]               bo_adr,
    input  logic [12:0]              bo_x_mcu,
    input  logic [12:0]              bo_y_mcu,
    output logic                     bi_next,
    input  logic                     fb_ready,
    output logic                     fb_we,
    output logic [FB_ADDR_WIDTH-1:0] fb_addr,
    output logic [11:0]              fb_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     err,
    output logic [19:0]              pix_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                   state_r;
    logic                     cfg_411_r;
    logic [12:0]              mcu_w_r;
    logic [12:0]              mcu_h_r;
    logic                     fb_we_r;
    logic [FB_ADDR_WIDTH-1:0] fb_addr_r;
    logic [11:0]              fb_data_r;
    logic                     busy_r;
    logic                     frame_done_r;
    logic                     err_r;
    logic [19:0]              pix_cnt_r;

    logic [16:0]              x_s;
    logic [16:0]              y_s;
    logic [7:0]               last_adr_s;
    logic                     adr_bad_s;
    logic                     range_bad_s;
    logic                     begin_bad_s;
    logic                     end_bad_s;
    logic                     beat_err_s;
    logic                     clip_s;
    logic                     bi_next_s;
    logic                     accept_s;
    logic                     load_s;
    logic                     drain_s;
    logic                     last_s;
    logic [FB_ADDR_WIDTH-1:0] pix_addr_s;
    logic [11:0]              pix_data_s;

`ifdef JPEG_PIXEL_SINK_ROUND_EN
    // Round a channel to 4 bits: (c+8)>>4 evaluated in 9 bits, saturated at 15.
    function automatic logic [3:0] round_nibble(input logic [7:0] c);
        logic [4:0] q;
        q = 5'(({1'b0, c} + 9'd8) >> 4);
        if (q > 5'd15) begin
            round_nibble = 4'hF;
        end else begin
            round_nibble = q[3:0];
        end
    endfunction
`else
    // Truncation discards the low colour bits by design.
    logic unused_bits_s;
    assign unused_bits_s = ^{bo_r[3:0], bo_g[3:0], bo_b[3:0]};
`endif

    // Decode the offered beat: raster position, legality, clipping and handshake.
    always_comb begin
        x_s        = 17'd0;
        y_s        = 17'd0;
        last_adr_s = 8'd63;
        adr_bad_s  = 1'b0;
        if (cfg_411_r) begin
            x_s        = {bo_x_mcu, 4'd0} + {13'd0, bo_adr[3:0]};
            y_s        = {bo_y_mcu, 4'd0} + {13'd0, bo_adr[7:4]};
            last_adr_s = 8'd255;
            adr_bad_s  = 1'b0;
        end else begin
            x_s        = {1'b0, bo_x_mcu, 3'd0} + {14'd0, bo_adr[2:0]};
            y_s        = {1'b0, bo_y_mcu, 3'd0} + {14'd0, bo_adr[5:3]};
            last_adr_s = 8'd63;
            adr_bad_s  = (bo_adr > 8'd63);
        end
        range_bad_s = (bo_x_mcu >= mcu_w_r) || (bo_y_mcu >= mcu_h_r);
        begin_bad_s = bo_begin && (bo_adr != 8'd0);
        end_bad_s   = bo_end && (bo_adr != last_adr_s);
        beat_err_s  = adr_bad_s || range_bad_s || begin_bad_s || end_bad_s;
        clip_s      = (32'(x_s) >= 32'(FB_W)) || (32'(y_s) >= 32'(FB_H));
        pix_addr_s  = FB_ADDR_WIDTH'(32'(y_s) * 32'(FB_W) + 32'(x_s));
`ifdef JPEG_PIXEL_SINK_ROUND_EN
        pix_data_s  = {round_nibble(bo_r), round_nibble(bo_g), round_nibble(bo_b)};
`else
        pix_data_s  = {bo_r[7:4], bo_g[7:4], bo_b[7:4]};
`endif
        bi_next_s   = (state_r == ACTIVE) && (!fb_we_r || fb_ready);
        accept_s    = bo_we && bi_next_s;
        load_s      = accept_s && !beat_err_s && !clip_s;
        drain_s     = fb_we_r && fb_ready;
        last_s      = accept_s && bo_end &&
                      (bo_x_mcu == (mcu_w_r - 13'd1)) &&
                      (bo_y_mcu == (mcu_h_r - 13'd1));
    end

    // Frame FSM together with the one-entry write register, pixel counter and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cfg_411_r    <= 1'b0;
            mcu_w_r      <= 13'd0;
            mcu_h_r      <= 13'd0;
            fb_we_r      <= 1'b0;
            fb_addr_r    <= {FB_ADDR_WIDTH{1'b0}};
            fb_data_r    <= 12'd0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            err_r        <= 1'b0;
            pix_cnt_r    <= 20'd0;
        end else begin
            if (load_s) begin
                fb_we_r   <= 1'b1;
                fb_addr_r <= pix_addr_s;
                fb_data_r <= pix_data_s;
            end else if (drain_s) begin
                fb_we_r   <= 1'b0;
            end
            if (drain_s) begin
                pix_cnt_r <= pix_cnt_r + 20'd1;
            end
            if (accept_s && beat_err_s) begin
                err_r <= 1'b1;
            end
            frame_done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (co_en) begin
                        cfg_411_r <= co_411;
                        mcu_w_r   <= co_mcu_w;
                        mcu_h_r   <= co_mcu_h;
                        if ((co_mcu_w == 13'd0) || (co_mcu_h == 13'd0)) begin
                            err_r <= 1'b1;
                        end else begin
                            state_r   <= ACTIVE;
                            busy_r    <= 1'b1;
                            pix_cnt_r <= 20'd0;
                        end
                    end
                end
                ACTIVE: begin
                    if (last_s) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The final pixel may still sit in a stalled register.
                    if (!fb_we_r || drain_s) begin
                        state_r      <= DONE;
                        frame_done_r <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bi_next    = bi_next_s;
    assign fb_we      = fb_we_r;
    assign fb_addr    = fb_addr_r;
    assign fb_data    = fb_data_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign err        = err_r;
    assign pix_cnt    = pix_cnt_r;

endmodule

// File: tb/tb_jpeg_pixel_sink.sv
// tb_jpeg_pixel_sink: scoreboard bench for jpeg_pixel_sink. The driver pushes
// the expected frame-buffer write of every accepted beat (from a geometric
// model of the MCU layout) and an independent monitor pops and compares on
// every fb_we/fb_ready handshake.
module tb_jpeg_pixel_sink;
    localparam int FB_W = 32;
    localparam int FB_H = 32;
    localparam int AW   = 10;
`ifdef JPEG_PIXEL_SINK_ROUND_EN
    localparam int RGB_MIX = 12'h1F7;
`else
    localparam int RGB_MIX = 12'h0F7;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          co_en;
    logic          co_411;
    logic [12:0]   co_mcu_w;
    logic [12:0]   co_mcu_h;
    logic          bo_we;
    logic          bo_begin;
    logic          bo_end;
    logic [7:0]    bo_r;
    logic [7:0]    bo_g;
    logic [7:0]    bo_b;
    logic [7:0]    bo_adr;
    logic [12:0]   bo_x_mcu;
    logic [12:0]   bo_y_mcu;
    logic          bi_next;
    logic          fb_ready;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [11:0]   fb_data;
    logic          busy;
    logic          frame_done;
    logic          err;
    logic [19:0]   pix_cnt;

    always #5 clk = ~clk;

    jpeg_pixel_sink #(.FB_W(FB_W), .FB_H(FB_H), .FB_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .co_en(co_en), .co_411(co_411),
        .co_mcu_w(co_mcu_w), .co_mcu_h(co_mcu_h), .bo_we(bo_we),
        .bo_begin(bo_begin), .bo_end(bo_end), .bo_r(bo_r), .bo_g(bo_g),
        .bo_b(bo_b), .bo_adr(bo_adr), .bo_x_mcu(bo_x_mcu), .bo_y_mcu(bo_y_mcu),
        .bi_next(bi_next), .fb_ready(fb_ready), .fb_we(fb_we),
        .fb_addr(fb_addr), .fb_data(fb_data), .busy(busy),
        .frame_done(frame_done), .err(err), .pix_cnt(pix_cnt)
    );

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_q[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  done_cnt    = 0;
    bit  rand_rdy    = 1'b0;
    bit  exp_err     = 1'b0;
    bit  cfg411      = 1'b0;
    int  cfg_w       = 0;
    int  cfg_h       = 0;

    task automatic check(input string name, input int act, input int want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    function automatic int nib(input int c);
`ifdef JPEG_PIXEL_SINK_ROUND_EN
        int v;
        v = (c + 8) / 16;
        return (v > 15) ? 15 : v;
`else
        return c / 16;
`endif
    endfunction

    // Reference: where a beat lands, and whether it is written at all.
    task automatic model_accept(input int xm, input int ym, input int adr,
                                input int r, input int g, input int b,
                                input bit bg, input bit en);
        int d, x, y;
        bit bad;
        wr_t e;
        d   = cfg411 ? 16 : 8;
        bad = (adr >= d * d) || (xm >= cfg_w) || (ym >= cfg_h) ||
              (bg && adr != 0) || (en && adr != d * d - 1);
        x   = xm * d + adr % d;
        y   = ym * d + adr / d;
        if (bad) begin
            exp_err = 1'b1;
        end else if (x < FB_W && y < FB_H) begin
            e.addr = (y * FB_W + x) % (1 << AW);
            e.data = (nib(r) << 8) | (nib(g) << 4) | nib(b);
            exp_q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input bit m411, input int w, input int h);
        co_en = 1'b1; co_411 = m411; co_mcu_w = 13'(w); co_mcu_h = 13'(h);
        cfg411 = m411; cfg_w = w; cfg_h = h;
        tick();
        co_en = 1'b0;
    endtask

    task automatic send(input int xm, input int ym, input int adr,
                        input int r, input int g, input int b,
                        input bit bg, input bit en);
        int  waited;
        bit  taken;
        waited = 0;
        taken  = 1'b0;
        bo_x_mcu = 13'(xm); bo_y_mcu = 13'(ym); bo_adr = 8'(adr);
        bo_r = 8'(r); bo_g = 8'(g); bo_b = 8'(b);
        bo_begin = bg; bo_end = en; bo_we = 1'b1;
        while (!taken && waited <= 200) begin
            @(negedge clk);
            if (bi_next) begin
                taken = 1'b1;
            end else begin
                waited++;
                @(posedge clk);
                #1;
            end
        end
        if (taken) begin
            model_accept(xm, ym, adr, r, g, b, bg, en);
            @(posedge clk);
            #1;
        end else begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: beat (%0d,%0d,%0d) not accepted after %0d cycles, expected acceptance", xm, ym, adr, waited);
        end
        bo_we = 1'b0; bo_begin = 1'b0; bo_end = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            vectors++;
            miscompares++;
            $display("FAIL idle_timeout: busy still 1 after %0d cycles, expected 0", n);
        end
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_bi_next"},    int'(bi_next), 0);
        check({tag, "_fb_we"},      int'(fb_we), 0);
        check({tag, "_fb_addr"},    int'(fb_addr), 0);
        check({tag, "_fb_data"},    int'(fb_data), 0);
        check({tag, "_busy"},       int'(busy), 0);
        check({tag, "_frame_done"}, int'(frame_done), 0);
        check({tag, "_err"},        int'(err), 0);
        check({tag, "_pix_cnt"},    int'(pix_cnt), 0);
    endtask

    // fb_ready randomiser, active only during randomised traffic.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) fb_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: scoreboard pops on each write handshake; stalled writes must hold.
    initial begin : monitor
        bit  stall_prev;
        int  addr_prev;
        int  data_prev;
        wr_t e;
        stall_prev = 1'b0;
        addr_prev  = 0;
        data_prev  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("hold_fb_we",   int'(fb_we), 1);
                    check("hold_fb_addr", int'(fb_addr), addr_prev);
                    check("hold_fb_data", int'(fb_data), data_prev);
                end
                if (frame_done) begin
                    done_cnt++;
                    check("writes_pending_at_done", exp_q.size(), 0);
                end
                if (fb_we && fb_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", fb_addr, fb_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_fb_addr", int'(fb_addr), e.addr);
                        check("sb_fb_data", int'(fb_data), e.data);
                    end
                end
                stall_prev = fb_we && !fb_ready;
                addr_prev  = int'(fb_addr);
                data_prev  = int'(fb_data);
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done0, r, g, b;
        rst = 1'b1; co_en = 1'b0; co_411 = 1'b0; co_mcu_w = 13'd0; co_mcu_h = 13'd0;
        bo_we = 1'b0; bo_begin = 1'b0; bo_end = 1'b0; bo_r = 8'd0; bo_g = 8'd0;
        bo_b = 8'd0; bo_adr = 8'd0; bo_x_mcu = 13'd0; bo_y_mcu = 13'd0; fb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_reset_outputs("por");
        tick();
        rst = 1'b0;

        // Basic 8x8 pixel, then backpressure with simultaneous drain and load.
        done0 = done_cnt;
        start_frame(1'b0, 4, 4);
        check("basic_busy", int'(busy), 1);
        send(1, 2, 9, 'hAB, 'h12, 'hFF, 1'b0, 1'b0);
        @(negedge clk);
        check("basic_fb_we",   int'(fb_we), 1);
        check("basic_fb_addr", int'(fb_addr), 553);
        check("basic_fb_data", int'(fb_data), (nib('hAB) << 8) | (nib('h12) << 4) | nib('hFF));
        tick();
        fb_ready = 1'b0;
        send(0, 0, 1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b0);
        r = $urandom_range(0, 255); g = $urandom_range(0, 255); b = $urandom_range(0, 255);
        bo_x_mcu = 13'd0; bo_y_mcu = 13'd0; bo_adr = 8'd2;
        bo_r = 8'(r); bo_g = 8'(g); bo_b = 8'(b); bo_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_bi_next", int'(bi_next), 0);
            check("stall_fb_we", int'(fb_we), 1);
            tick();
        end
        fb_ready = 1'b1;
        send(0, 0, 2, r, g, b, 1'b0, 1'b0);
        send(3, 3, 63, 'h55, 'hAA, 'h33, 1'b0, 1'b1);
        wait_idle();
        check("basic_done_pulses", done_cnt - done0, 1);
        check("basic_pix_cnt", int'(pix_cnt), 4);
        check("basic_err", int'(err), int'(exp_err));
        check("basic_bi_next_idle", int'(bi_next), 0);

        // Full 4x4-MCU 8x8 frame with random colours, gaps and fb_ready.
        done0 = done_cnt;
        start_frame(1'b0, 4, 4);
        check("full_pix_cnt_clear", int'(pix_cnt), 0);
        rand_rdy = 1'b1;
        for (int ym = 0; ym < 4; ym++) begin
            for (int xm = 0; xm < 4; xm++) begin
                for (int a = 0; a < 64; a++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    send(xm, ym, a, $urandom_range(0, 255), $urandom_range(0, 255),
                         $urandom_range(0, 255), a == 0, a == 63);
                end
            end
        end
        wait_idle();
        rand_rdy = 1'b0;
        fb_ready = 1'b1;
        check("full_done_pulses", done_cnt - done0, 1);
        check("full_pix_cnt", int'(pix_cnt), 1024);
        check("full_err", int'(err), 0);
        check("full_busy", int'(busy), 0);
        check("full_sb_empty", exp_q.size(), 0);

        // 4:1:1 geometry and clipping.
        done0 = done_cnt;
        start_frame(1'b1, 3, 2);
        send(2, 0, 'h05, 'h11, 'h22, 'h33, 1'b0, 1'b0);
        @(negedge clk);
        check("clip_no_we", int'(fb_we), 0);
        tick();
        send(1, 0, 'hFF, 'hC0, 'hD0, 'hE0, 1'b0, 1'b0);
        @(negedge clk);
        check("m411_fb_addr", int'(fb_addr), 511);
        tick();
        send(2, 1, 'hFF, 'h01, 'h02, 'h03, 1'b0, 1'b1);
        wait_idle();
        check("m411_done_pulses", done_cnt - done0, 1);
        check("m411_pix_cnt", int'(pix_cnt), 1);
        check("m411_err", int'(err), 0);

        // Protocol errors: illegal adr, bad begin; legal pixels still written.
        done0 = done_cnt;
        start_frame(1'b0, 4, 4);
        send(0, 0, 70, 'h12, 'h34, 'h56, 1'b0, 1'b0);
        @(negedge clk);
        check("badadr_err", int'(err), 1);
        check("badadr_no_we", int'(fb_we), 0);
        tick();
        send(1, 1, 0, 'h08, 'hF8, 'h77, 1'b1, 1'b0);
        @(negedge clk);
        check("colour_fb_data", int'(fb_data), RGB_MIX);
        check("colour_fb_addr", int'(fb_addr), 264);
        tick();
        send(0, 0, 5, 'h99, 'h99, 'h99, 1'b1, 1'b0);
        send(3, 3, 63, 'h44, 'h55, 'h66, 1'b0, 1'b1);
        wait_idle();
        check("errf_done_pulses", done_cnt - done0, 1);
        check("errf_pix_cnt", int'(pix_cnt), 2);
        check("errf_err", int'(err), int'(exp_err));

        // Zero MCU width at co_en: error, no frame.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        co_en = 1'b1; co_411 = 1'b0; co_mcu_w = 13'd0; co_mcu_h = 13'd4;
        tick();
        co_en = 1'b0;
        tick();
        @(negedge clk);
        check("zerodim_busy", int'(busy), 0);
        check("zerodim_err", int'(err), 1);
        check("zerodim_bi_next", int'(bi_next), 0);
        tick();

        // Reset during a stalled write, then a clean frame.
        start_frame(1'b0, 4, 4);
        fb_ready = 1'b0;
        send(0, 0, 0, 'hAA, 'hBB, 'hCC, 1'b1, 1'b0);
        @(negedge clk);
        check("midrst_pre_we", int'(fb_we), 1);
        check("midrst_pre_busy", int'(busy), 1);
        tick();
        rst = 1'b1;
        exp_err = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        tick();
        fb_ready = 1'b1;
        done0 = done_cnt;
        start_frame(1'b0, 1, 1);
        check("restart_pix_cnt", int'(pix_cnt), 0);
        check("restart_busy", int'(busy), 1);
        send(0, 0, 0, 'h10, 'h20, 'h30, 1'b1, 1'b0);
        send(0, 0, 63, 'hF0, 'hE0, 'hD0, 1'b0, 1'b1);
        wait_idle();
        check("restart_done_pulses", done_cnt - done0, 1);
        check("restart_pix_cnt_end", int'(pix_cnt), 2);
        check("restart_err", int'(err), 0);
        check("restart_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
